pkt_tx_ctrl: RTL and testbench

Read side of the per-port packet FIFO. It pops committed packets from the synchronous FIFO and parses each header. Packets addressed to this port go out on a valid/ready byte stream with start-of-packet and end-of-packet markers. Misaddressed packets are drained silently and counted as drops. It sits between the output FIFO and the router output port. The FIFO exposes only committed packets, so every byte of a packet is present once its header is visible.

---
 rtl/router_pkg.sv | 24 ++
 rtl/out_slot_reg.sv | 46 ++++
 rtl/pkt_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_pkt_tx_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths, header field helpers and transmit state encoding for the router output path.
// No logic; imported by the transmit controller and its output register.
// Not applicable: the package carries no flow control.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    TX_HDR  = 2'd0,
    TX_BODY = 2'd1,
    TX_DROP = 2'd2
  } tx_state_e;

  // LEN occupies the header bits below the destination field
  function automatic int len_width(input int dw, input int aw);
    return dw - aw;
  endfunction

  function automatic int dst_lsb(input int dw, input int aw);
    return dw - aw;
  endfunction

endpackage

// File: rtl/out_slot_reg.sv
// Single-entry output register carrying data plus packet boundary markers.
// Latency: a loaded byte is presented the cycle after load.
// Backpressure: holds all outputs while out_valid && !out_ready; can_load tells the producer when a load is taken.
module out_slot_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_sop,
  input  logic                  ld_eop,
  input  logic                  out_ready,
  output logic                  can_load,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (can_load) begin
      if (load) begin
        out_data  <= ld_data;
        out_valid <= 1'b1;
        out_sop   <= ld_sop;
        out_eop   <= ld_eop;
      end else begin
        // slot drained with nothing new: keep the stale byte, drop the markers
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_ctrl.sv
// Pops committed packets from the port FIFO, forwards those addressed to PORT_ID, drains and counts the rest.
// Latency: a popped byte appears on out_data one cycle later; 1 byte/cycle sustained.
// Backpressure: out_ready low freezes the slot and stops pops, except while draining a misaddressed packet.
module pkt_tx_ctrl
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PORT_ID    = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int LW    = len_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int DST_L = dst_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] PORT_ADDR = ADDR_WIDTH'(PORT_ID);

  tx_state_e       state_r, state_nxt;
  logic [LW:0]     rem_r, rem_nxt;
  logic            can_load;
  logic            header_drop;
  logic            load;
  logic            ld_sop;
  logic            ld_eop;
  logic            drop_inc;
  logic [ADDR_WIDTH-1:0] hdr_dst;
  logic [LW-1:0]   hdr_len;

  assign hdr_dst     = fifo_data[DST_L +: ADDR_WIDTH];
  assign hdr_len     = fifo_data[LW-1:0];
  assign header_drop = (state_r == TX_HDR) && (hdr_dst != PORT_ADDR);
  // misaddressed bytes never need the output slot, so they drain under backpressure
  assign fifo_pop    = !fifo_empty && ((state_r == TX_DROP) || header_drop || can_load);
  assign busy        = (state_r != TX_HDR) || out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= TX_HDR;
      rem_r   <= '0;
    end else begin
      state_r <= state_nxt;
      rem_r   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    rem_nxt   = rem_r;
    load      = 1'b0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_r)
      TX_HDR: begin
        if (fifo_pop) begin
          // LEN payload bytes plus the CRC still to come
          rem_nxt = {1'b0, hdr_len} + (LW + 1)'(1);
          if (header_drop) begin
            state_nxt = TX_DROP;
          end else begin
            load      = 1'b1;
            ld_sop    = 1'b1;
            state_nxt = TX_BODY;
          end
        end
      end
      TX_BODY: begin
        if (fifo_pop) begin
          load    = 1'b1;
          rem_nxt = rem_r - (LW + 1)'(1);
          if (rem_r == (LW + 1)'(1)) begin
            ld_eop    = 1'b1;
            state_nxt = TX_HDR;
          end
        end
      end
      TX_DROP: begin
        if (fifo_pop) begin
          rem_nxt = rem_r - (LW + 1)'(1);
          if (rem_r == (LW + 1)'(1)) begin
            drop_inc  = 1'b1;
            state_nxt = TX_HDR;
          end
        end
      end
      default: state_nxt = TX_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_valid && out_ready && out_eop) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
      if (drop_inc) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  out_slot_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .ld_data   (fifo_data),
    .ld_sop    (ld_sop),
    .ld_eop    (ld_eop),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
  );

endmodule

// File: tb/tb_pkt_tx_ctrl.sv
// Bench for pkt_tx_ctrl: behavioural committed FIFO in front, scoreboard of expected stream bytes behind.
module tb_pkt_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pop_cnt = 0;
  int exp_sent = 0;

  logic [7:0] mem [0:511];
  logic [8:0] wr_ptr = '0;
  logic [8:0] rd_ptr = '0;

  logic [9:0] exp_q [$];
  int         hs_cyc_q [$];

  always #5 clk = ~clk;

  pkt_tx_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .busy       (busy),
    .sent_cnt   (sent_cnt),
    .drop_cnt   (drop_cnt)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  // FIFO shares rst_n with the DUT, so reset flushes it
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_pop) rd_ptr <= rd_ptr + 9'd1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_pop) begin
        checks++;
        pop_cnt++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL pop_when_empty: fifo_pop=1 while fifo_empty=1 at cycle %0d", cyc);
        end
      end
      if (out_valid && out_ready) begin
        logic [9:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got data=%h sop=%0b eop=%0b, required no output", out_data, out_sop, out_eop);
        end else begin
          e = exp_q.pop_front();
          if ({out_sop, out_eop, out_data} !== e) begin
            errors++;
            $display("FAIL stream_byte: got sop=%0b eop=%0b data=%h, required sop=%0b eop=%0b data=%h",
                     out_sop, out_eop, out_data, e[9], e[8], e[7:0]);
          end
        end
        hs_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_out, input bit sop, input bit eop);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 9'd1;
    if (expect_out) exp_q.push_back({sop, eop, b});
  endtask

  // Whole packet is written in zero time, matching commit-only FIFO visibility
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] pay [$], input logic [7:0] crc, input bit fwd);
    push_byte(hdr, fwd, 1'b1, 1'b0);
    foreach (pay[i]) push_byte(pay[i], fwd, 1'b0, 1'b0);
    push_byte(crc, fwd, 1'b0, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d bytes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sent(input string name);
    checks++;
    if (sent_cnt !== 16'(exp_sent)) begin
      errors++;
      $display("FAIL %s_sent_cnt: got %0d, required %0d", name, sent_cnt, exp_sent);
    end
  endtask

  task automatic check_contiguous(input string name, input int nbytes);
    checks++;
    if (hs_cyc_q.size() != nbytes) begin
      errors++;
      $display("FAIL %s_count: got %0d handshakes, required %0d", name, hs_cyc_q.size(), nbytes);
    end else if (hs_cyc_q[nbytes-1] - hs_cyc_q[0] != nbytes - 1) begin
      errors++;
      $display("FAIL %s_gap: stream spanned %0d cycles, required %0d", name,
               hs_cyc_q[nbytes-1] - hs_cyc_q[0] + 1, nbytes);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_sop, out_eop, busy, fifo_pop} !== 5'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b sop=%0b eop=%0b busy=%0b pop=%0b data=%h, required all 0",
               out_valid, out_sop, out_eop, busy, fifo_pop, out_data);
    end
    checks++;
    if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got sent=%0d drop=%0d, required 0 0", sent_cnt, drop_cnt);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pay [$] = '{8'hA1, 8'hA2, 8'hA3};
    @(posedge clk); #1;
    hs_cyc_q.delete();
    push_pkt(8'h03, pay, 8'hC5, 1'b1);
    wait_drain("basic", 30);
    exp_sent = 1;
    check_sent("basic");
    check_contiguous("basic", 5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pay [$] = '{8'hA1, 8'hA2, 8'hA3};
    int n = 0;
    int pops0;
    @(posedge clk); #1;
    push_pkt(8'h03, pay, 8'hC5, 1'b1);
    while (!(out_valid && out_data == 8'hA2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    pops0 = pop_cnt;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_sop !== 1'b0 || fifo_pop !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b data=%h sop=%0b pop=%0b, required 1 a2 0 0",
                 out_valid, out_data, out_sop, fifo_pop);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pop_cnt != pops0) begin
      errors++;
      $display("FAIL stall_pops: got %0d pops during stall, required 0", pop_cnt - pops0);
    end
    out_ready = 1'b1;
    wait_drain("stall", 30);
    exp_sent = 2;
    check_sent("stall");
  endtask

  task automatic test_drop();
    logic [7:0] pay [$] = '{8'hB1, 8'hB2};
    logic [7:0] none [$];
    int pops0;
    @(posedge clk); #1;
    pops0 = pop_cnt;
    push_pkt(8'h42, pay, 8'hCC, 1'b0);
    push_pkt(8'h00, none, 8'h7E, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_output: got out_valid=%0b on drain cycle %0d, required 0", out_valid, i);
      end
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
    end
    wait_drain("drop", 30);
    exp_sent = 3;
    check_sent("drop");
    checks++;
    if (pop_cnt - pops0 != 6) begin
      errors++;
      $display("FAIL drop_pops: got %0d pops, required 6", pop_cnt - pops0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] none [$];
    @(posedge clk); #1;
    hs_cyc_q.delete();
    push_pkt(8'h00, none, 8'h11, 1'b1);
    push_pkt(8'h00, none, 8'h22, 1'b1);
    wait_drain("b2b", 30);
    exp_sent = 5;
    check_sent("b2b");
    check_contiguous("b2b", 4);
  endtask

  task automatic test_long();
    logic [7:0] pay [$];
    for (int i = 0; i < 63; i++) pay.push_back(8'(i + 1));
    @(posedge clk); #1;
    hs_cyc_q.delete();
    push_pkt(8'h3F, pay, 8'h5A, 1'b1);
    wait_drain("long", 120);
    exp_sent = 6;
    check_sent("long");
    check_contiguous("long", 65);
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL long_drop_cnt: got %0d, required 1", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay [$];
    logic [7:0] pay2 [$] = '{8'hD0};
    int n = 0;
    for (int i = 0; i < 63; i++) pay.push_back(8'(8'h80 + i));
    @(posedge clk); #1;
    hs_cyc_q.delete();
    push_pkt(8'h3F, pay, 8'h99, 1'b1);
    while (hs_cyc_q.size() < 5 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midpkt_active: got valid=%0b busy=%0b, required 1 1", out_valid, busy);
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_reset_state: got valid=%0b busy=%0b sop=%0b eop=%0b, required 0 0 0 0",
               out_valid, busy, out_sop, out_eop);
    end
    checks++;
    if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midpkt_reset_counters: got sent=%0d drop=%0d, required 0 0", sent_cnt, drop_cnt);
    end
    @(posedge clk); #1;
    hs_cyc_q.delete();
    push_pkt(8'h01, pay2, 8'hEE, 1'b1);
    wait_drain("post_reset", 30);
    exp_sent = 1;
    check_sent("post_reset");
    check_contiguous("post_reset", 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_back_to_back();
    test_long();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
